ro_puf_challenger: RTL

Synchronous challenge/response controller that drives the ring-oscillator PUF array from the system clock domain. For each response bit it selects an oscillator pair, clears and enables the pair's ripple counters for a fixed gate window, and lets the counters settle. It then compares the two counts and shifts the result into a response word. It sits between the host/test interface and the free-running oscillator/counter macro, acting as the initiator for the oscillator-and-counter responder.

---
 rtl/ro_puf_challenger.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ro_puf_challenger.sv
// ---------------------------------------------------------------------------
// ro_puf_challenger
//
// Challenge/response controller for the ring-oscillator PUF array. For each
// response bit it performs these steps:
//   - select an oscillator pair derived from the challenge,
//   - pulse the counter clear,
//   - gate the pair for WINDOW cycles and wait SETTLE cycles,
//   - compare the two counts and store the result as response[k].
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   start               begin a challenge (accepted only in IDLE)
//   abort               cancel a run in progress
//   challenge[7:0]      challenge word, latched on start acceptance
//   cnt_a, cnt_b [7:0]  counts of the oscillators selected by ro_sel_a/b
//   ro_sel_a/b [2:0]    oscillator indices of the current pair
//   ro_en               oscillator/counter gate enable
//   cnt_clr             counter clear pulse
//   busy                run in progress
//   resp_valid          one-cycle pulse when response is complete
//   response[NBITS-1:0] response word, bit k = result of pair k
//   tie_cnt[3:0]        number of equal-count bits in the last run (sat. 15)
// ---------------------------------------------------------------------------
module ro_puf_challenger #(
  parameter int NBITS  = 8,
  parameter int WINDOW = 64,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       challenge,
  input  logic [7:0]       cnt_a,
  input  logic [7:0]       cnt_b,
  output logic [2:0]       ro_sel_a,
  output logic [2:0]       ro_sel_b,
  output logic             ro_en,
  output logic             cnt_clr,
  output logic             busy,
  output logic             resp_valid,
  output logic [NBITS-1:0] response,
  output logic [3:0]       tie_cnt
);

  // The phase timer counts 0..N-1 inside RUN and SETTLE.
  localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] WIN_LAST = TW'(WINDOW - 1);
  localparam logic [TW-1:0] SET_LAST = TW'(SETTLE - 1);
  localparam logic [TW-1:0] TMR_ZERO = TW'(0);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [3:0]    BIT_LAST = 4'(NBITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t            state_r, state_s;
  logic [TW-1:0]     tmr_r, tmr_s;
  logic [3:0]        bit_r;
  logic [5:0]        chal_r;
  logic              abort_hit_s;
  logic              accept_s;
  logic              tie_s;
  logic [NBITS-1:0]  resp_upd_s;
  logic [3:0]        tie_upd_s;
  logic [2:0]        sel_k_s;
  logic [5:0]        chal_src_s;
  logic [5:0]        sel_next_s;
  logic              unused_chal_s;

  // Reserved challenge bits carry no function.
  assign unused_chal_s = ^challenge[7:6];

  // Pair mapping: A = c[2:0] + k (mod 8), B = A ^ off, where a zero offset
  // is forced to 1 so that A and B can never select the same oscillator.
  function automatic logic [5:0] pair_sel(input logic [5:0] c, input logic [2:0] k);
    logic [2:0] a;
    logic [2:0] off;
    a   = c[2:0] + k;
    off = (c[5:3] == 3'd0) ? 3'd1 : c[5:3];
    return {a, a ^ off};
  endfunction

  // Abort and start qualification.
  always_comb begin
    abort_hit_s = abort && (state_r != ST_IDLE);
    accept_s    = start && (state_r == ST_IDLE);
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_s = state_r;
    if (abort_hit_s) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) state_s = ST_CLEAR;
          else       state_s = ST_IDLE;
        end
        ST_CLEAR:  state_s = ST_RUN;
        ST_RUN: begin
          if (tmr_r == WIN_LAST) state_s = ST_SETTLE;
          else                   state_s = ST_RUN;
        end
        ST_SETTLE: begin
          if (tmr_r == SET_LAST) state_s = ST_SAMPLE;
          else                   state_s = ST_SETTLE;
        end
        ST_SAMPLE: begin
          if (bit_r == BIT_LAST) state_s = ST_DONE;
          else                   state_s = ST_CLEAR;
        end
        ST_DONE:   state_s = ST_IDLE;
        default:   state_s = ST_IDLE;
      endcase
    end
  end

  // Phase timer: restarts on every state change, counts only in RUN/SETTLE.
  always_comb begin
    tmr_s = TMR_ZERO;
    if ((state_s == state_r) && ((state_r == ST_RUN) || (state_r == ST_SETTLE))) begin
      tmr_s = tmr_r + TMR_ONE;
    end else begin
      tmr_s = TMR_ZERO;
    end
  end

  // Sample-time update of the response word and the saturating tie counter.
  always_comb begin
    tie_s      = (cnt_a == cnt_b);
    resp_upd_s = response;
    for (int i = 0; i < NBITS; i++) begin
      if (bit_r == 4'(i)) resp_upd_s[i] = (cnt_a > cnt_b);
      else                resp_upd_s[i] = response[i];
    end
    if (tie_s && (tie_cnt != 4'hF)) tie_upd_s = tie_cnt + 4'd1;
    else                            tie_upd_s = tie_cnt;
  end

  // Pair for the upcoming CLEAR: bit 0 from the live challenge on acceptance,
  // otherwise the next bit of the latched challenge.
  always_comb begin
    if (state_r == ST_IDLE) begin
      sel_k_s    = 3'd0;
      chal_src_s = challenge[5:0];
    end else begin
      sel_k_s    = bit_r[2:0] + 3'd1;
      chal_src_s = chal_r;
    end
    sel_next_s = pair_sel(chal_src_s, sel_k_s);
  end

  // State and phase timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      tmr_r   <= TMR_ZERO;
    end else begin
      state_r <= state_s;
      tmr_r   <= tmr_s;
    end
  end

  // Registered control outputs, decoded from the next state so they line up
  // with the state they belong to; selects change only on entry to CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ro_en      <= 1'b0;
      cnt_clr    <= 1'b0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      ro_sel_a   <= 3'd0;
      ro_sel_b   <= 3'd0;
    end else begin
      ro_en      <= (state_s == ST_RUN);
      cnt_clr    <= (state_s == ST_CLEAR);
      busy       <= (state_s != ST_IDLE);
      resp_valid <= (state_s == ST_DONE);
      if (state_s == ST_CLEAR) begin
        ro_sel_a <= sel_next_s[5:3];
        ro_sel_b <= sel_next_s[2:0];
      end
    end
  end

  // Challenge latch, bit index, response word and tie counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chal_r   <= 6'd0;
      bit_r    <= 4'd0;
      response <= {NBITS{1'b0}};
      tie_cnt  <= 4'd0;
    end else if (abort_hit_s) begin
      response <= {NBITS{1'b0}};
      tie_cnt  <= 4'd0;
    end else if (accept_s) begin
      chal_r   <= challenge[5:0];
      bit_r    <= 4'd0;
      response <= {NBITS{1'b0}};
      tie_cnt  <= 4'd0;
    end else if (state_r == ST_SAMPLE) begin
      response <= resp_upd_s;
      tie_cnt  <= tie_upd_s;
      if (bit_r != BIT_LAST) bit_r <= bit_r + 4'd1;
    end
  end

endmodule
